// File: rtl/sipo_frame_pkg.sv
// Shared types and constants for the serial frame receiver controller.
package sipo_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  // Level of the serial line when no frame is in progress.
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/sipo_frame_ctrl_shift.sv
// WIDTH-bit left-shift register fed at the LSB, with shift enable and
// synchronous clear. The first bit shifted in ends up in the MSB.
module sipo_shift_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  // Next value: clear wins over shift, otherwise hold.
  always_comb begin
    shift_d = shift_q;
    if (clr) begin
      shift_d = '0;
    end else if (en) begin
      shift_d = {shift_q[WIDTH-2:0], din};
    end
  end

  // Shift register storage.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign q = shift_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Serial frame receiver controller: start-bit detect, WIDTH data bits
// (MSB first), optional even parity, stop-bit check, and a one-entry
// valid/ready holding register towards the parallel consumer.
module sipo_frame_ctrl
  import sipo_frame_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             flush,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_q, par_d;
  logic [WIDTH-1:0] p_data_q, p_data_d;
  logic             p_valid_q, p_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
  logic             overrun_q, overrun_d;
  logic             start_det;
  logic [WIDTH-1:0] shift_word;

  // A start bit is a strobed low level seen while idle.
  assign start_det = (state_q == IDLE) && s_valid && (s_in != LINE_IDLE);

  sipo_shift_en #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk (clk),
    .clr (reset | flush | start_det),
    .en  ((state_q == DATA) && s_valid),
    .din (s_in),
    .q   (shift_word)
  );

  // Frame sequencing, parity accumulation, delivery and error decisions.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    par_d        = par_q;
    p_data_d     = p_data_q;
    p_valid_d    = p_valid_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;

    // Consumer pop; a same-cycle delivery below re-asserts valid.
    if (p_valid_q && p_ready) begin
      p_valid_d = 1'b0;
    end

    if (s_valid) begin
      unique case (state_q)
        IDLE: begin
          if (start_det) begin
            state_d = DATA;
            cnt_d   = '0;
            par_d   = 1'b0;
          end
        end
        DATA: begin
          par_d = par_q ^ s_in;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PARITY: begin
          // Even parity: accumulated XOR including this bit must be 0.
          par_d   = par_q ^ s_in;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (s_in != LINE_IDLE) begin
            frame_err_d = 1'b1;
          end else if (PARITY_EN && par_q) begin
            parity_err_d = 1'b1;
          end else if (!p_valid_q || p_ready) begin
            p_data_d  = shift_word;
            p_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Abort drops the in-flight frame and the held word but keeps p_data.
    if (flush) begin
      state_d      = IDLE;
      cnt_d        = '0;
      par_d        = 1'b0;
      p_valid_d    = 1'b0;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  // State, counter, holding register and error pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      par_q        <= 1'b0;
      p_data_q     <= '0;
      p_valid_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      par_q        <= par_d;
      p_data_q     <= p_data_d;
      p_valid_q    <= p_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign p_data     = p_data_q;
  assign p_valid    = p_valid_q;
  assign busy       = (state_q != IDLE);
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl: one instance without parity, one with.
module tb_sipo_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset, s_in, s_valid, flush, p_ready;

  logic [7:0] p_data0, p_data1;
  logic       p_valid0, p_valid1, busy0, busy1;
  logic       ferr0, ferr1, perr0, perr1, ovr0, ovr1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.WIDTH(8), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .s_in(s_in), .s_valid(s_valid), .flush(flush),
    .p_data(p_data0), .p_valid(p_valid0), .p_ready(p_ready), .busy(busy0),
    .frame_err(ferr0), .parity_err(perr0), .overrun(ovr0)
  );

  sipo_frame_ctrl #(.WIDTH(8), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .s_in(s_in), .s_valid(s_valid), .flush(flush),
    .p_data(p_data1), .p_valid(p_valid1), .p_ready(p_ready), .busy(busy1),
    .frame_err(ferr1), .parity_err(perr1), .overrun(ovr1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Optional idle gap, then one strobed bit.
  task automatic send_bit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      step();
    end
    s_in    = b;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    s_in    = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit with_par, input logic par,
                            input logic stop);
    send_bit(1'b0, 0);
    for (int i = 7; i >= 0; i--) send_bit(d[i], 0);
    if (with_par) send_bit(par, 0);
    send_bit(stop, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [9:0] bits;
    reset = 1'b0; s_in = 1'b1; s_valid = 1'b0; flush = 1'b0; p_ready = 1'b1;
    step();
    do_reset();

    // Reset state
    check("rst_pdata0", p_data0, 8'h00);
    check("rst_pvalid0", p_valid0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_errs0", {ferr0, perr0, ovr0}, 3'b000);
    check("rst_pvalid1", p_valid1, 0);
    check("rst_busy1", busy1, 0);

    // Basic frame 0xA5, no parity
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    check("a5_pdata", p_data0, 8'hA5);
    check("a5_pvalid", p_valid0, 1);
    check("a5_errs", {ferr0, perr0, ovr0}, 3'b000);
    check("a5_busy", busy0, 0);
    step();
    check("a5_pvalid_pop", p_valid0, 0);

    // Parity: good then bad
    do_reset();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    check("par_ok_pdata", p_data1, 8'hA5);
    check("par_ok_pvalid", p_valid1, 1);
    check("par_ok_perr", perr1, 0);
    step();
    check("par_ok_pop", p_valid1, 0);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    check("par_bad_perr", perr1, 1);
    check("par_bad_pvalid", p_valid1, 0);
    check("par_bad_ferr", ferr1, 0);
    step();
    check("par_bad_pulse_end", perr1, 0);

    // Framing error, then recovery
    do_reset();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("ferr_pulse", ferr0, 1);
    check("ferr_pvalid", p_valid0, 0);
    check("ferr_busy", busy0, 0);
    step();
    check("ferr_pulse_end", ferr0, 0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    check("ferr_next_pdata", p_data0, 8'h81);
    check("ferr_next_pvalid", p_valid0, 1);
    step();

    // Overrun and simultaneous pop/push
    do_reset();
    p_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    check("ovr_first_pdata", p_data0, 8'h11);
    check("ovr_first_pvalid", p_valid0, 1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    check("ovr_pulse", ovr0, 1);
    check("ovr_hold_pdata", p_data0, 8'h11);
    check("ovr_hold_pvalid", p_valid0, 1);
    step();
    check("ovr_pulse_end", ovr0, 0);
    check("ovr_stable_pdata", p_data0, 8'h11);
    send_bit(1'b0, 0);
    for (int i = 7; i >= 0; i--) send_bit(bits_of(8'h33, i), 0);
    p_ready = 1'b1;
    send_bit(1'b1, 0);
    check("pushpop_pdata", p_data0, 8'h33);
    check("pushpop_pvalid", p_valid0, 1);
    check("pushpop_ovr", ovr0, 0);
    step();
    check("pushpop_pop", p_valid0, 0);

    // Strobe gaps with busy tracking
    do_reset();
    bits = {1'b0, 8'h5A, 1'b1};
    for (int i = 9; i >= 0; i--) begin
      send_bit(bits[i], int'($urandom_range(0, 3)));
      if (i > 0) check("gap_busy", busy0, 1);
      else       check("gap_busy_end", busy0, 0);
    end
    check("gap_pdata", p_data0, 8'h5A);
    check("gap_pvalid", p_valid0, 1);
    step();

    // Reset mid-frame (at data bit 4)
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    check("midrst_busy_before", busy0, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_busy", busy0, 0);
    check("midrst_pvalid", p_valid0, 0);
    check("midrst_pdata", p_data0, 8'h00);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    check("midrst_next_pdata", p_data0, 8'hC3);
    check("midrst_next_pvalid", p_valid0, 1);
    step();

    // Flush with a held word and a frame in flight
    p_ready = 1'b0;
    send_frame(8'h77, 1'b0, 1'b0, 1'b1);
    check("flush_held_pvalid", p_valid0, 1);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", busy0, 0);
    check("flush_pvalid", p_valid0, 0);
    check("flush_pdata_kept", p_data0, 8'h77);
    p_ready = 1'b1;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    check("flush_next_pdata", p_data0, 8'hC3);
    check("flush_next_pvalid", p_valid0, 1);
    check("flush_next_errs", {ferr0, perr0, ovr0}, 3'b000);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  function automatic logic bits_of(input logic [7:0] d, input int i);
    return d[i];
  endfunction

endmodule
